rx_dispatch: RTL

- Receive-side counterpart of the transmit-side FIFO selector.
- Takes bytes from the UART receiver, parses framed packets and writes each payload into one of three channel FIFOs (m2/m5/m7 write ports).
- These FIFOs are the ones the selector later drains for transmission.
- Sits between the UART RX core and the m2/m5/m7 FIFO write sides, in the clk_24m domain.

---
 rtl/rx_dispatch_pkg.sv | 51 +++++
 rtl/rx_dispatch_edge_sync.sv | 27 ++
 rtl/rx_dispatch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rx_dispatch_pkg.sv
// Purpose: constants and types shared by the rx dispatcher, the tx selector and its framer.
// Latency: n/a (definitions only).
// Backpressure: n/a. The checksum state exists only when RXD_CHECKSUM_EN is defined.
package rx_dispatch_pkg;

    // Framing bytes and channel IDs
    localparam logic [7:0] SOF   = 8'hA5;
    localparam logic [7:0] ID_M2 = 8'h02;
    localparam logic [7:0] ID_M5 = 8'h05;
    localparam logic [7:0] ID_M7 = 8'h07;

    // Abort causes reported on err_code
    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_ID   = 3'd1;
    localparam logic [2:0] ERR_LEN  = 3'd2;
    localparam logic [2:0] ERR_TMO  = 3'd3;
    localparam logic [2:0] ERR_CSUM = 3'd4;

    // One-hot parser state encodings
`ifdef RXD_CHECKSUM_EN
    localparam int ST_W = 5;
`else
    localparam int ST_W = 4;
`endif
    localparam logic [ST_W-1:0] ST_HUNT_OH = ST_W'(1) << 0;
    localparam logic [ST_W-1:0] ST_CHAN_OH = ST_W'(1) << 1;
    localparam logic [ST_W-1:0] ST_LEN_OH  = ST_W'(1) << 2;
    localparam logic [ST_W-1:0] ST_DATA_OH = ST_W'(1) << 3;
`ifdef RXD_CHECKSUM_EN
    localparam logic [ST_W-1:0] ST_CSUM_OH = ST_W'(1) << 4;
`endif

    typedef enum logic [ST_W-1:0] {
        ST_HUNT = ST_HUNT_OH,
        ST_CHAN = ST_CHAN_OH,
        ST_LEN  = ST_LEN_OH,
        ST_DATA = ST_DATA_OH
`ifdef RXD_CHECKSUM_EN
        ,
        ST_CSUM = ST_CSUM_OH
`endif
    } rxd_state_e;

    // Destination FIFO selected by the ID byte
    typedef enum logic [1:0] {
        CH_M2 = 2'd0,
        CH_M5 = 2'd1,
        CH_M7 = 2'd2
    } rxd_chan_e;

endpackage

// File: rtl/rx_dispatch_edge_sync.sv
// Purpose: two-flop level register plus rising-edge strobe for a byte-done/idle handshake.
// Latency: stb_o is high in the cycle after the first edge that samples lvl_i=1.
// Backpressure: none; one strobe per rising edge of lvl_i.
module rx_edge_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic lvl_i,
    output logic stb_o
);

    logic r0_q;
    logic r1_q;

    // Shift the level through two flops; the strobe marks a 0->1 transition
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r0_q <= 1'b0;
            r1_q <= 1'b0;
        end else begin
            r0_q <= lvl_i;
            r1_q <= r0_q;
        end
    end

    assign stb_o = r0_q & ~r1_q;

endmodule

// File: rtl/rx_dispatch.sv
// Purpose: parse SOF/ID/LEN/payload[/CSUM] frames from the UART RX and write payloads to m2/m5/m7 FIFOs.
// Latency: a byte is acted on one edge after rx_done is first sampled high; wren/wr_data show the cycle after.
// Backpressure: none upstream; a payload byte arriving on a full FIFO is dropped and sets sticky ovf.
// Build option: define RXD_CHECKSUM_EN to add a trailing XOR checksum byte (ID ^ LEN ^ payload).
module rx_dispatch
    import rx_dispatch_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 64,
    parameter int unsigned TIMEOUT_CYC = 24000
) (
    input  logic       clk_24m,
    input  logic       rstn,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       m2_full,
    input  logic       m5_full,
    input  logic       m7_full,
    output logic [7:0] wr_data,
    output logic       m2_wren,
    output logic       m5_wren,
    output logic       m7_wren,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       ovf
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic             stb;
    logic [7:0]       byte_q;
    logic [7:0]       byte_d;
    rxd_state_e       state_q;
    rxd_chan_e        chan_q;
    logic [7:0]       rem_q;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;
    logic             tmo_expire;
    logic             sel_full;
    logic             len_bad;

    logic [7:0]       wr_data_q;
    logic             m2_wren_q;
    logic             m5_wren_q;
    logic             m7_wren_q;
    logic             frame_ok_q;
    logic             frame_err_q;
    logic [2:0]       err_code_q;
    logic             ovf_q;
`ifdef RXD_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    rx_edge_sync u_edge_sync (
        .clk_i   (clk_24m),
        .rst_n_i (rstn),
        .lvl_i   (rx_done),
        .stb_o   (stb)
    );

    // Byte register loads on the strobe; the parser sees the fresh byte in that same cycle
    always_comb begin
        byte_d = stb ? rx_data : byte_q;
    end

    // Full flag of the currently selected FIFO, used unregistered at the write decision
    always_comb begin
        sel_full = 1'b0;
        case (chan_q)
            CH_M2:   sel_full = m2_full;
            CH_M5:   sel_full = m5_full;
            CH_M7:   sel_full = m7_full;
            default: sel_full = 1'b0;
        endcase
    end

    // LEN byte is legal only in 1..MAX_LEN
    always_comb begin
        len_bad = (byte_d == 8'd0) || ({24'd0, byte_d} > MAX_LEN);
    end

    // Inter-byte gap counter: idle in HUNT, cleared by every byte, expires at TIMEOUT_CYC
    always_comb begin
        tmo_expire = 1'b0;
        if (stb || (state_q == ST_HUNT)) begin
            tmo_d = '0;
        end else begin
            tmo_d      = tmo_q + 1'b1;
            tmo_expire = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
        end
    end

    // Frame parser with registered write/status outputs; a byte beats a same-cycle timeout
    always_ff @(posedge clk_24m) begin
        if (!rstn) begin
            byte_q      <= 8'd0;
            state_q     <= ST_HUNT;
            chan_q      <= CH_M2;
            rem_q       <= 8'd0;
            tmo_q       <= '0;
            wr_data_q   <= 8'd0;
            m2_wren_q   <= 1'b0;
            m5_wren_q   <= 1'b0;
            m7_wren_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            ovf_q       <= 1'b0;
`ifdef RXD_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            byte_q      <= byte_d;
            tmo_q       <= tmo_d;
            m2_wren_q   <= 1'b0;
            m5_wren_q   <= 1'b0;
            m7_wren_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (stb) begin
                case (state_q)
                    ST_HUNT: begin
                        // Anything but SOF is line noise between frames
                        if (byte_d == SOF) begin
                            state_q <= ST_CHAN;
                        end
                    end
                    ST_CHAN: begin
`ifdef RXD_CHECKSUM_EN
                        csum_q <= byte_d;
`endif
                        case (byte_d)
                            ID_M2: begin
                                chan_q  <= CH_M2;
                                state_q <= ST_LEN;
                            end
                            ID_M5: begin
                                chan_q  <= CH_M5;
                                state_q <= ST_LEN;
                            end
                            ID_M7: begin
                                chan_q  <= CH_M7;
                                state_q <= ST_LEN;
                            end
                            default: begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_ID;
                                state_q     <= ST_HUNT;
                            end
                        endcase
                    end
                    ST_LEN: begin
`ifdef RXD_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_d;
`endif
                        if (len_bad) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= ST_HUNT;
                        end else begin
                            rem_q   <= byte_d;
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
`ifdef RXD_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_d;
`endif
                        // Dropped bytes still consume LEN so framing stays aligned
                        if (sel_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wr_data_q <= byte_d;
                            case (chan_q)
                                CH_M2:   m2_wren_q <= 1'b1;
                                CH_M5:   m5_wren_q <= 1'b1;
                                CH_M7:   m7_wren_q <= 1'b1;
                                default: m2_wren_q <= 1'b0;
                            endcase
                        end
                        rem_q <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
`ifdef RXD_CHECKSUM_EN
                            state_q <= ST_CSUM;
`else
                            frame_ok_q <= 1'b1;
                            state_q    <= ST_HUNT;
`endif
                        end
                    end
`ifdef RXD_CHECKSUM_EN
                    ST_CSUM: begin
                        // Payload is already in the FIFO; a mismatch only flags the frame
                        if (byte_d == csum_q) begin
                            frame_ok_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CSUM;
                        end
                        state_q <= ST_HUNT;
                    end
`endif
                    default: begin
                        state_q <= ST_HUNT;
                    end
                endcase
            end else if (tmo_expire) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TMO;
                state_q     <= ST_HUNT;
            end
        end
    end

    assign wr_data   = wr_data_q;
    assign m2_wren   = m2_wren_q;
    assign m5_wren   = m5_wren_q;
    assign m7_wren   = m7_wren_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign ovf       = ovf_q;

endmodule
